ensamblador_mensaje: RTL and testbench
======================================

# ensamblador_mensaje

Downstream neighbour of the nonce generator. Each nonce it accepts is latched together with the current block data into one message, which it then streams byte by byte, MSB first, into the hash core. The next nonce is not accepted until the hash core reports completion. Only one message is in flight at any time.

## Interface
- BLOQUE_BYTES, 12: block-data bytes per message.
- NONCE_BYTES, 1: nonce bytes per message (generator nonce is 8 bits).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset. The active-high polarity and synchronous behaviour are fixed.
- bloque_in  input  8*BLOQUE_BYTES  block data; sampled only on nonce acceptance.
- nonce  input  8*NONCE_BYTES  nonce from the generator.
- nonce_valid  input  1  nonce is valid this cycle.
- nonce_ready  output  1  block can accept a nonce.
- out_data  output  8  message byte to the hash core.
- out_valid  output  1  out_data is valid.
- out_last  output  1  marks the final message byte.
- out_ready  input  1  hash core accepts a byte.
- hash_done  input  1  one-cycle pulse when the hash core finishes the message.
- busy  output  1  high whenever the block is not in IDLE.

## Operation
- MSG_BYTES = BLOQUE_BYTES + NONCE_BYTES.
- Message layout: {bloque_in, nonce}, sent MSB byte first. All block bytes go out before the nonce bytes.
- FSM states: IDLE, SEND, WAIT. All outputs are registered.
- IDLE:
  - nonce_ready=1, busy=0.
  - When nonce_valid && nonce_ready, the message loads into the shift register, cnt=0, and the FSM moves to SEND.
  - On that same edge: out_valid<=1, out_data<=message MSB byte, nonce_ready<=0, busy<=1.
- SEND:
  - A byte transfers on out_valid && out_ready.
  - On each transfer the register shifts left by 8, cnt increments, and out_data loads the next byte.
  - out_last=1 exactly when cnt==MSG_BYTES-1.
  - A transfer with out_last=1 clears out_valid and out_last and moves the FSM to WAIT.
- WAIT:
  - Outputs idle: out_valid=0, busy=1.
  - hash_done moves the FSM to IDLE and sets nonce_ready<=1 on the same edge.
- hash_done is ignored in IDLE and SEND.
- nonce_valid is ignored outside IDLE. The generator holds the nonce until it is accepted.
- cnt width is $clog2(MSG_BYTES). cnt never wraps: it resets to 0 on each load.

## Timing
- Reset values:
  - nonce_ready=0, out_valid=0, out_last=0, out_data=8'h00, busy=0.
  - Shift register 0, cnt 0, state IDLE.
- nonce_ready rises on the first edge after reset deasserts.
- Latency:
  - First byte is valid in the cycle after the acceptance edge.
  - With out_ready held high, one byte per cycle, giving MSG_BYTES cycles in SEND.
- Backpressure: while out_valid && !out_ready, out_data, out_valid and out_last hold stable. No byte is dropped or duplicated.
- Turnaround: hash_done seen at edge N gives nonce_ready=1 after edge N, so a new nonce is accepted at edge N+1 at the earliest.
- Reset mid-operation (any state):
  - Next edge returns all outputs and registers to their reset values.
  - The partial message is discarded and hash_done is not awaited.
- A change in bloque_in after acceptance has no effect on the message in flight.
- MSG_BYTES=1 is legal: the first byte carries out_last=1.

## Structure
- Shared package holds: BLOQUE_BYTES and NONCE_BYTES defaults, MSG_BYTES, the FSM state encoding (IDLE=2'd0, SEND=2'd1, WAIT=2'd2), and byte width 8.
- One natural sub-module: serializador_bytes. It contains the shift register, cnt, and out_data/out_valid/out_last with the hold-under-backpressure logic.
- The top level keeps the FSM and the nonce handshake.

## Test plan
- Reset for 3 cycles, then release:
  - All outputs are 0 during reset.
  - nonce_ready=1 one edge after release.
  - busy=0.
- bloque_in=96'h000102030405060708090A0B, nonce=8'hA5, out_ready=1:
  - 13 consecutive bytes 00,01,…,0B,A5.
  - out_last=1 only on A5.
  - Then WAIT with busy=1.
- Same stimulus with out_ready toggled 1,0,0,1,…:
  - Byte sequence is identical.
  - out_data holds stable during every stall.
- Sequencing around hash_done:
  - nonce_valid asserted during SEND and WAIT: no acceptance.
  - hash_done pulsed in SEND: ignored.
  - hash_done pulsed in WAIT: nonce_ready=1 next cycle, and the second nonce 8'h3C streams ending in 3C.
- reset asserted on the 5th byte:
  - out_valid=0 next edge.
  - Following nonce 8'h11 produces a full fresh 13-byte message ending in 11.

Source files
------------

// File: rtl/ensamblador_mensaje_pkg.sv
// Shared definitions for the message assembler: sizes, byte width,
// FSM state encoding and a counter-width helper.
package ensamblador_mensaje_pkg;

  localparam int BYTE_W           = 8;
  localparam int BLOQUE_BYTES_DEF = 12;
  localparam int NONCE_BYTES_DEF  = 1;
  localparam int MSG_BYTES        = BLOQUE_BYTES_DEF + NONCE_BYTES_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } estado_t;

  // Counter width for n bytes. A one-byte message still needs a 1-bit
  // counter, because $clog2(1) would give a zero-width vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ensamblador_mensaje_serializador_bytes.sv
// Byte serializer: holds a whole message in a shift register and presents
// it MSB byte first. Outputs stay put while the consumer stalls.
module serializador_bytes
  import ensamblador_mensaje_pkg::*;
#(
  parameter int MSG_BYTES_P = MSG_BYTES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [BYTE_W*MSG_BYTES_P-1:0] msg_in,
  input  logic                          out_ready,
  output logic [BYTE_W-1:0]             out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic                          fin
);

  localparam int MSG_W = BYTE_W * MSG_BYTES_P;
  localparam int CNT_W = cnt_width(MSG_BYTES_P);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_BYTES_P - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [MSG_W-1:0]  shreg_r;
  logic [MSG_W-1:0]  shreg_nx_s;
  logic [MSG_W-1:0]  shifted_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nx_s;
  logic [BYTE_W-1:0] out_data_r;
  logic [BYTE_W-1:0] data_nx_s;
  logic              out_valid_r;
  logic              valid_nx_s;
  logic              out_last_r;
  logic              last_nx_s;
  logic              xfer_s;

  // Next-state of the shift register, counter and byte outputs.
  always_comb begin
    xfer_s     = out_valid_r && out_ready;
    shifted_s  = shreg_r << BYTE_W;
    shreg_nx_s = shreg_r;
    cnt_nx_s   = cnt_r;
    data_nx_s  = out_data_r;
    valid_nx_s = out_valid_r;
    last_nx_s  = out_last_r;
    if (load) begin
      shreg_nx_s = msg_in;
      cnt_nx_s   = {CNT_W{1'b0}};
      data_nx_s  = msg_in[MSG_W-1 -: BYTE_W];
      valid_nx_s = 1'b1;
      last_nx_s  = (CNT_LAST == {CNT_W{1'b0}});
    end else if (xfer_s) begin
      shreg_nx_s = shifted_s;
      if (out_last_r) begin
        // Final byte accepted: go quiet, counter holds (never wraps).
        valid_nx_s = 1'b0;
        last_nx_s  = 1'b0;
      end else begin
        cnt_nx_s   = cnt_r + CNT_ONE;
        data_nx_s  = shifted_s[MSG_W-1 -: BYTE_W];
        last_nx_s  = ((cnt_r + CNT_ONE) == CNT_LAST);
      end
    end else begin
      // Stalled or idle: everything holds.
      shreg_nx_s = shreg_r;
    end
  end

  // Serializer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r     <= {MSG_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_data_r  <= {BYTE_W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      shreg_r     <= shreg_nx_s;
      cnt_r       <= cnt_nx_s;
      out_data_r  <= data_nx_s;
      out_valid_r <= valid_nx_s;
      out_last_r  <= last_nx_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign fin       = xfer_s && out_last_r;

endmodule

// File: rtl/ensamblador_mensaje.sv
// Message assembler: accepts a nonce, latches it with the block data and
// streams the message to the hash core, then waits for hash_done before
// accepting the next nonce. One message in flight at a time.
module ensamblador_mensaje
  import ensamblador_mensaje_pkg::*;
#(
  parameter int BLOQUE_BYTES = BLOQUE_BYTES_DEF,
  parameter int NONCE_BYTES  = NONCE_BYTES_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BYTE_W*BLOQUE_BYTES-1:0] bloque_in,
  input  logic [BYTE_W*NONCE_BYTES-1:0]  nonce,
  input  logic                           nonce_valid,
  output logic                           nonce_ready,
  output logic [BYTE_W-1:0]              out_data,
  output logic                           out_valid,
  output logic                           out_last,
  input  logic                           out_ready,
  input  logic                           hash_done,
  output logic                           busy
);

  localparam int MSG_LEN = BLOQUE_BYTES + NONCE_BYTES;

  estado_t state_r;
  estado_t state_nx_s;
  logic    accept_s;
  logic    fin_s;
  logic    nonce_ready_r;
  logic    nonce_ready_nx_s;
  logic    busy_r;
  logic    busy_nx_s;
  logic [BYTE_W*MSG_LEN-1:0] msg_s;

  assign msg_s = {bloque_in, nonce};

  serializador_bytes #(
    .MSG_BYTES_P (MSG_LEN)
  ) u_serializador (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_s),
    .msg_in    (msg_s),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .fin       (fin_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; hash_done only matters in WAIT, nonces only in IDLE.
  always_comb begin
    accept_s   = (state_r == ST_IDLE) && nonce_valid && nonce_ready_r;
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_SEND;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (fin_s) begin
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (hash_done) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs follow the state being entered, so they are
  // registered yet line up with the state on the same edge.
  always_comb begin
    nonce_ready_nx_s = 1'b0;
    busy_nx_s        = 1'b0;
    if (state_nx_s == ST_IDLE) begin
      nonce_ready_nx_s = 1'b1;
      busy_nx_s        = 1'b0;
    end else begin
      nonce_ready_nx_s = 1'b0;
      busy_nx_s        = 1'b1;
    end
  end

  // Handshake output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      nonce_ready_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      nonce_ready_r <= nonce_ready_nx_s;
      busy_r        <= busy_nx_s;
    end
  end

  assign nonce_ready = nonce_ready_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ensamblador_mensaje.sv
// Self-checking bench for ensamblador_mensaje: table of messages with
// expected first/last bytes, a byte-queue reference model, randomized
// backpressure and block data, plus reset and hash_done sequences.
module tb_ensamblador_mensaje;

  localparam int MB = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] bloque_in;
  logic [7:0]  nonce;
  logic        nonce_valid;
  logic        nonce_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        hash_done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  ensamblador_mensaje dut (
    .clk         (clk),
    .reset       (reset),
    .bloque_in   (bloque_in),
    .nonce       (nonce),
    .nonce_valid (nonce_valid),
    .nonce_ready (nonce_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .hash_done   (hash_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] blq;
    logic [7:0]  nc;
    int          mode;      // 0: ready high, 1: ready 1,0,0 pattern, 2: random
    bit          disturb;   // nonce_valid + hash_done poked during SEND/WAIT
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: byte i of the message {block, nonce}, MSB first.
  function automatic logic [7:0] model_byte(input logic [95:0] blq, input logic [7:0] nc, input int i);
    logic [8*MB-1:0] m;
    m = {blq, nc};
    m = m >> (8 * (MB - 1 - i));
    return m[7:0];
  endfunction

  // Offer one message, consume it, check it, then release with hash_done.
  task automatic run_msg(input logic [95:0] blq, input logic [7:0] nc, input int mode,
                         input bit disturb, output logic [7:0] first_b, output logic [7:0] last_b);
    logic [7:0] expq[$];
    logic [7:0] exp_b;
    logic [7:0] hd;
    logic       hl;
    int         guard;
    int         n;
    int         cyc;
    int         k;
    bit         done;
    bit         stalled;
    bit         pulsed;
    bit         rdy;
    guard = 0; n = 0; cyc = 0; k = 0; done = 0; stalled = 0; pulsed = 0;
    hd = 8'h00; hl = 1'b0; first_b = 8'h00; last_b = 8'h00;
    for (int i = 0; i < MB; i++) expq.push_back(model_byte(blq, nc, i));
    while (nonce_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_load", nonce_ready, 1'b1);
    bloque_in   = blq;
    nonce       = nc;
    nonce_valid = 1'b1;
    out_ready   = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", busy, 1'b1);
    chk("ready_after_accept", nonce_ready, 1'b0);
    if (disturb) nonce = 8'hEE;
    else nonce_valid = 1'b0;
    // Block data changes after acceptance must not affect the message.
    bloque_in = {$urandom, $urandom, $urandom};
    while (!done && cyc < 200) begin
      if (stalled) begin
        chk("stall_data", out_data, hd);
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_last", out_last, hl);
      end
      chk("valid_in_send", out_valid, 1'b1);
      if (out_valid !== 1'b1) begin
        done = 1;
      end else begin
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) rdy = (k % 3 == 0);
        else rdy = ($urandom_range(0, 1) == 1);
        k++;
        out_ready = rdy;
        if (rdy) begin
          exp_b = (expq.size() > 0) ? expq.pop_front() : 8'hXX;
          chk("byte", out_data, exp_b);
          chk("last_flag", out_last, (n == MB - 1));
          if (n == 0) first_b = out_data;
          last_b = out_data;
          n++;
          if (out_last === 1'b1 || n >= MB) done = 1;
          stalled = 0;
        end else begin
          stalled = 1;
          hd = out_data;
          hl = out_last;
        end
      end
      hash_done = disturb && !pulsed && (n == 3);
      if (hash_done) pulsed = 1;
      @(negedge clk);
      hash_done = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    chk("byte_count", n, MB);
    chk("wait_valid", out_valid, 1'b0);
    chk("wait_last", out_last, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("wait_busy", busy, 1'b1);
      chk("wait_ready", nonce_ready, 1'b0);
    end
    hash_done = 1'b1;
    @(negedge clk);
    hash_done   = 1'b0;
    nonce_valid = 1'b0;
    chk("done_ready", nonce_ready, 1'b1);
    chk("done_busy", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  fb;
    logic [7:0]  lb;
    logic [95:0] rb;
    logic [7:0]  rn;

    tbl[0] = '{96'h000102030405060708090A0B, 8'hA5, 0, 1'b0, 8'h00, 8'hA5};
    tbl[1] = '{96'h000102030405060708090A0B, 8'hA5, 1, 1'b0, 8'h00, 8'hA5};
    tbl[2] = '{96'hFFEEDDCCBBAA998877665544, 8'h5A, 0, 1'b1, 8'hFF, 8'h5A};
    tbl[3] = '{96'h0123456789ABCDEF02468ACE, 8'h3C, 2, 1'b0, 8'h01, 8'h3C};

    reset = 1'b1; bloque_in = 96'h0; nonce = 8'h00; nonce_valid = 1'b0;
    out_ready = 1'b0; hash_done = 1'b0;

    // Reset held for three cycles: every output low.
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {nonce_ready, out_valid, out_last, busy, out_data}, 12'h000);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", nonce_ready, 1'b1);
    chk("busy_after_reset", busy, 1'b0);

    // hash_done in IDLE is ignored.
    hash_done = 1'b1;
    @(negedge clk);
    hash_done = 1'b0;
    chk("idle_hash_done_ready", nonce_ready, 1'b1);
    chk("idle_hash_done_busy", busy, 1'b0);

    // Table-driven messages.
    for (int v = 0; v < 4; v++) begin
      run_msg(tbl[v].blq, tbl[v].nc, tbl[v].mode, tbl[v].disturb, fb, lb);
      chk("tbl_first", fb, tbl[v].exp_first);
      chk("tbl_last", lb, tbl[v].exp_last);
    end

    // Reset while the 5th byte is presented.
    bloque_in = 96'h101112131415161718191A1B; nonce = 8'h77;
    nonce_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    nonce_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("fifth_byte", out_data, 8'h14);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_valid", out_valid, 1'b0);
    chk("midreset_outputs", {nonce_ready, out_last, busy, out_data}, 11'h000);
    reset = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("midreset_ready", nonce_ready, 1'b1);
    run_msg(96'hCAFEBABEDEADBEEF13579BDF, 8'h11, 0, 1'b0, fb, lb);
    chk("fresh_first", fb, 8'hCA);
    chk("fresh_last", lb, 8'h11);

    // Random messages under random backpressure.
    for (int r = 0; r < 6; r++) begin
      rb = {$urandom, $urandom, $urandom};
      rn = 8'($urandom);
      run_msg(rb, rn, 2, 1'b0, fb, lb);
      chk("rand_first", fb, rb[95:88]);
      chk("rand_last", lb, rn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
